// File: rtl/tbm_master.sv
// Burst initiator for a 32-byte-word memory port.
// Ports: req_* burst request, wr_* write beats, rd_* read beats,
//        done completion pulse, cs_0/we_0/address_0/data_0 memory side.
module tbm_master #(
    parameter int MEM_WIDTH  = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_LEN    = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [4:0]            req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [MEM_WIDTH-1:0]  wr_data,
    output logic                  rd_valid,
    output logic [MEM_WIDTH-1:0]  rd_data,
    output logic                  done,
    output logic                  cs_0,
    output logic                  we_0,
    output logic [ADDR_WIDTH-1:0] address_0,
    inout  wire  [MEM_WIDTH-1:0]  data_0
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int OW = $clog2(RD_LATENCY + 2);

    typedef enum logic [2:0] {
        IDLE, WRITE, READ, DRAIN, DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LW-1:0]         cnt_q;
    logic [LW-1:0]         len_d;
    logic [MEM_WIDTH-1:0]  wdata_q;
    logic [RD_LATENCY-1:0] rpipe_q;
    logic [OW-1:0]         os_q;
    logic [OW-1:0]         os_d;
    logic                  issue;
    logic                  ret;
    logic                  last;

    always_comb begin
        addr_d = addr_q + ADDR_WIDTH'(32);
        issue  = (state_q == READ);
        // A command travels RD_LATENCY stages before its data is sampled.
        ret    = rpipe_q[RD_LATENCY-1];
        os_d   = os_q + OW'(issue) - OW'(ret);
        last   = (cnt_q == LW'(1));
        if (req_len == 5'd0)
            len_d = LW'(1);
        else if (int'(req_len) > MAX_LEN)
            len_d = LW'(MAX_LEN);
        else
            len_d = LW'(req_len);
    end

    assign req_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WRITE) && wr_valid;
    assign data_0    = (cs_0 && we_0) ? wdata_q : 'z;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            wdata_q   <= '0;
            rpipe_q   <= '0;
            os_q      <= '0;
            cs_0      <= 1'b0;
            we_0      <= 1'b0;
            address_0 <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
        end else begin
            rpipe_q  <= (rpipe_q << 1) | RD_LATENCY'(issue);
            os_q     <= os_d;
            rd_valid <= ret;
            if (ret)
                rd_data <= data_0;
            done <= (state_q == DONE);
            cs_0 <= 1'b0;
            we_0 <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= {req_addr[ADDR_WIDTH-1:5], 5'b0};
                        cnt_q   <= len_d;
                        state_q <= req_we ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        cs_0      <= 1'b1;
                        we_0      <= 1'b1;
                        address_0 <= addr_q;
                        wdata_q   <= wr_data;
                        addr_q    <= addr_d;
                        cnt_q     <= cnt_q - LW'(1);
                        if (last)
                            state_q <= DONE;
                    end
                end
                READ: begin
                    cs_0      <= 1'b1;
                    address_0 <= addr_q;
                    addr_q    <= addr_d;
                    cnt_q     <= cnt_q - LW'(1);
                    if (last)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (os_d == '0)
                        state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tbm_master.sv
// Directed and randomized bench for tbm_master against a memory model.
module tb_tbm_master;

    localparam int MW  = 256;
    localparam int AW  = 32;
    localparam int RDL = 1;
    localparam int ML  = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [4:0]    req_len;
    logic          wr_valid, wr_ready;
    logic [MW-1:0] wr_data;
    logic          rd_valid;
    logic [MW-1:0] rd_data;
    logic          done, cs_0, we_0;
    logic [AW-1:0] address_0;
    wire  [MW-1:0] data_0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [MW-1:0] bus_mem [logic [AW-1:0]];
    logic [MW-1:0] ref_mem [logic [AW-1:0]];
    logic          resp_en;
    logic [MW-1:0] resp_d;

    always #5 clock = ~clock;

    tbm_master #(
        .MEM_WIDTH(MW), .ADDR_WIDTH(AW),
        .RD_LATENCY(RDL), .MAX_LEN(ML)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_len(req_len), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .cs_0(cs_0), .we_0(we_0),
        .address_0(address_0), .data_0(data_0)
    );

    // Memory responder: single-cycle read, writes captured mid-cycle.
    always @(cs_0, we_0, address_0) begin
        resp_en = cs_0 && !we_0;
        resp_d  = bus_mem.exists(address_0) ? bus_mem[address_0] : '0;
    end
    assign data_0 = resp_en ? resp_d : 'z;

    always @(negedge clock)
        if (cs_0 && we_0)
            bus_mem[address_0] = data_0;

    task automatic chk(input string tag,
                       input logic [MW-1:0] obs,
                       input logic [MW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input int l);
        if (l == 0) return 1;
        if (l > ML) return ML;
        return l;
    endfunction

    function automatic logic [MW-1:0] rmem(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic do_write(input logic [AW-1:0] addr, input int len,
                            input int stall_at, input int stall_n,
                            input bit rnd, input bit seq_data);
        logic [AW-1:0] a;
        logic [MW-1:0] d;
        int n, issued, sl, cyc;
        bit v;
        a = addr & 32'hFFFF_FFE0;
        n = eff_len(len);
        issued = 0;
        sl = stall_n;
        cyc = 0;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = addr;
        req_len = len[4:0];
        #1 chk("wr_req_ready", MW'(req_ready), MW'(1));
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("wr_busy", MW'(req_ready), MW'(0));
        while (issued < n) begin
            if (cyc > 300) begin
                chk("wr_timeout", MW'(issued), MW'(n));
                break;
            end
            cyc++;
            if (issued == stall_at && sl > 0) begin
                v = 1'b0;
                sl--;
            end else if (rnd)
                v = ($urandom_range(0, 3) != 0);
            else
                v = 1'b1;
            d = seq_data ? MW'(issued + 1) : {8{$urandom}};
            wr_valid = v;
            wr_data = d;
            #1 chk("wr_ready", MW'(wr_ready), MW'(v));
            @(posedge clock); #1;
            chk("wr_cs", MW'(cs_0), MW'(v));
            chk("wr_done_lo", MW'(done), MW'(0));
            if (v) begin
                chk("wr_we", MW'(we_0), MW'(1));
                chk("wr_addr", MW'(address_0), MW'(a));
                chk("wr_data0", data_0, d);
                ref_mem[a] = d;
                a = a + 32'd32;
                issued++;
            end
        end
        wr_valid = 1'b0;
        @(posedge clock); #1;
        chk("wr_done", MW'(done), MW'(1));
        chk("wr_cs_off", MW'(cs_0), MW'(0));
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int len);
        logic [AW-1:0] a;
        logic [MW-1:0] q[$];
        int n;
        a = addr & 32'hFFFF_FFE0;
        n = eff_len(len);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = addr;
        req_len = len[4:0];
        #1 chk("rd_req_ready", MW'(req_ready), MW'(1));
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("rd_busy", MW'(req_ready), MW'(0));
        for (int t = 0; t <= n + RDL; t++) begin
            @(posedge clock); #1;
            chk("rd_cs", MW'(cs_0), MW'(t < n));
            if (t < n) begin
                chk("rd_we", MW'(we_0), MW'(0));
                chk("rd_addr", MW'(address_0), MW'(a));
                chk("rd_bus", data_0, rmem(a));
                q.push_back(rmem(a));
                a = a + 32'd32;
            end
            chk("rd_valid", MW'(rd_valid),
                MW'(t >= RDL && t < n + RDL));
            if (rd_valid && q.size() > 0)
                chk("rd_data", rd_data, q.pop_front());
            chk("rd_done", MW'(done), MW'(t == n + RDL));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_len = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        #2;
        chk("rst_cs", MW'(cs_0), MW'(0));
        chk("rst_we", MW'(we_0), MW'(0));
        chk("rst_addr", MW'(address_0), MW'(0));
        chk("rst_rdv", MW'(rd_valid), MW'(0));
        chk("rst_rdd", rd_data, MW'(0));
        chk("rst_done", MW'(done), MW'(0));
        @(posedge clock);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_ready", MW'(req_ready), MW'(1));

        do_write(32'h40, 4, -1, 0, 1'b0, 1'b1);
        do_read(32'h40, 4);
        do_write(32'h100, 3, 1, 2, 1'b0, 1'b0);
        do_read(32'h100, 3);
        do_read(32'h3F, 2);
        do_write(32'hFFFF_FFE0, 2, -1, 0, 1'b0, 1'b0);
        do_read(32'hFFFF_FFE0, 2);
        do_write(32'h200, 0, -1, 0, 1'b0, 1'b0);
        do_write(32'h220, 20, -1, 0, 1'b1, 1'b0);
        do_read(32'h200, 20);

        for (int i = 0; i < 6; i++) begin
            logic [AW-1:0] ra;
            int rl;
            ra = $urandom;
            rl = $urandom_range(0, 20);
            do_write(ra, rl, -1, 0, 1'b1, 1'b0);
            do_read(ra, rl);
        end

        // Abort a len=8 read during its third command beat.
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h40;
        req_len = 5'd8;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 chk("abort_cs_pre", MW'(cs_0), MW'(1));
        reset_n = 1'b0;
        #1;
        chk("abort_cs", MW'(cs_0), MW'(0));
        chk("abort_we", MW'(we_0), MW'(0));
        chk("abort_addr", MW'(address_0), MW'(0));
        chk("abort_rdv", MW'(rd_valid), MW'(0));
        chk("abort_rdd", rd_data, MW'(0));
        chk("abort_done", MW'(done), MW'(0));
        chk("abort_wrr", MW'(wr_ready), MW'(0));
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        chk("abort_ready", MW'(req_ready), MW'(1));
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            chk("abort_no_rdv", MW'(rd_valid), MW'(0));
            chk("abort_no_done", MW'(done), MW'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
